// File: rtl/slv_guard_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module   : slv_guard_cfg_regs
// Brief    : Register-bus target for the slave guard configuration space.
//            Holds enable, ten phase budgets, W1C violation status and an
//            interrupt mask; answers each access with a one-cycle ACK.
// Revision : 1.0 - initial release
// ============================================================================
module slv_guard_cfg_regs #(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          CntWidth  = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter type reg_req_t = struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [31:0]          wdata;
        logic [3:0]           wstrb;
        logic                 valid;
    },
    parameter type reg_rsp_t = struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    }
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  reg_req_t                      reg_req_i,
    output reg_rsp_t                      reg_rsp_o,
    output logic                          enable_o,
    output logic [9:0][CntWidth-1:0]      budget_o,
    output logic                          cfg_done_o,
    input  logic [9:0]                    viol_i,
    output logic                          irq_o
);

    localparam logic [AddrWidth-1:0] OFF_CTRL   = AddrWidth'(32'h00);
    localparam logic [AddrWidth-1:0] OFF_STATUS = AddrWidth'(32'h2C);
    localparam logic [AddrWidth-1:0] OFF_MASK   = AddrWidth'(32'h30);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             error_q, error_d;
    logic             enable_q, enable_d;
    logic [9:0][31:0] budget_q, budget_d;
    logic [9:0]       written_q, written_d;
    logic [9:0]       status_q, status_d;
    logic [9:0]       mask_q, mask_d;
    logic             irq_q, irq_d;

    logic [AddrWidth-1:0] w_off;
    logic                 w_err;
    logic [31:0]          w_bmask;
    logic [31:0]          w_rdata;
    logic [9:0]           w_clr;

    // Address decode: the window is 0x00..0x30, word aligned, at or above BaseAddr
    always_comb begin
        w_off   = reg_req_i.addr - BaseAddr;
        w_err   = (reg_req_i.addr < BaseAddr) || (w_off[1:0] != 2'b00) || (w_off > OFF_MASK);
        w_bmask = {{8{reg_req_i.wstrb[3]}}, {8{reg_req_i.wstrb[2]}},
                   {8{reg_req_i.wstrb[1]}}, {8{reg_req_i.wstrb[0]}}};
        w_rdata = '0;
        if (w_off == OFF_CTRL) begin
            w_rdata = {31'd0, enable_q};
        end
        if (w_off == OFF_STATUS) begin
            w_rdata = {22'd0, status_q};
        end
        if (w_off == OFF_MASK) begin
            w_rdata = {22'd0, mask_q};
        end
        for (int i = 0; i < 10; i++) begin
            if (w_off == AddrWidth'(4 * (i + 1))) begin
                w_rdata = budget_q[i];
            end
        end
    end

    // Handshake FSM plus register write side effects, all taken on the IDLE->ACK edge
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        enable_d  = enable_q;
        budget_d  = budget_q;
        written_d = written_q;
        mask_d    = mask_q;
        w_clr     = '0;
        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    state_d = ACK;
                    error_d = w_err;
                    rdata_d = w_err ? 32'd0 : w_rdata;
                    if (!w_err && reg_req_i.write) begin
                        if (w_off == OFF_CTRL && reg_req_i.wstrb[0]) begin
                            enable_d = reg_req_i.wdata[0];
                        end
                        if (w_off == OFF_STATUS) begin
                            w_clr = reg_req_i.wdata[9:0] & w_bmask[9:0];
                        end
                        if (w_off == OFF_MASK) begin
                            mask_d = (mask_q & ~w_bmask[9:0]) | (reg_req_i.wdata[9:0] & w_bmask[9:0]);
                        end
                        for (int i = 0; i < 10; i++) begin
                            if (w_off == AddrWidth'(4 * (i + 1))) begin
                                budget_d[i]  = (budget_q[i] & ~w_bmask) | (reg_req_i.wdata & w_bmask);
                                written_d[i] = written_q[i] | (|reg_req_i.wstrb);
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Violation pulses win over a simultaneous W1C clear; irq follows the next status
    always_comb begin
        status_d = (status_q & ~w_clr) | viol_i;
        irq_d    = |(status_d & mask_q);
    end

    // State and register storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            enable_q  <= 1'b0;
            budget_q  <= '0;
            written_q <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            enable_q  <= enable_d;
            budget_q  <= budget_d;
            written_q <= written_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
        end
    end

    // Response: ready only in ACK, so it drops as soon as reset forces IDLE
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
        reg_rsp_o.ready = (state_q == ACK);
    end

    assign enable_o   = enable_q;
    assign cfg_done_o = &written_q;
    assign irq_o      = irq_q;

    for (genvar g = 0; g < 10; g++) begin : g_budget
        assign budget_o[g] = budget_q[g][CntWidth-1:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_slv_guard_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_slv_guard_cfg_regs
// Brief    : Directed self-checking bench for slv_guard_cfg_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slv_guard_cfg_regs;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_t;

    logic             clk;
    logic             rst_n;
    req_t             req;
    rsp_t             rsp;
    logic             enable;
    logic [9:0][31:0] budget;
    logic             cfg_done;
    logic [9:0]       viol;
    logic             irq;

    int checks;
    int failures;

    logic [31:0] rd;
    logic        er;
    logic        ack_en;
    logic        ack_done;

    slv_guard_cfg_regs #(
        .AddrWidth (32),
        .CntWidth  (32),
        .BaseAddr  (32'h0),
        .reg_req_t (req_t),
        .reg_rsp_t (rsp_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .reg_req_i  (req),
        .reg_rsp_o  (rsp),
        .enable_o   (enable),
        .budget_o   (budget),
        .cfg_done_o (cfg_done),
        .viol_i     (viol),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access: drive on a negedge, expect ready at the following negedge
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [9:0] v);
        int n;
        @(negedge clk);
        req.addr = a; req.write = w; req.wdata = d; req.wstrb = s; req.valid = 1'b1;
        viol = v;
        @(negedge clk);
        req.valid = 1'b0;
        viol = '0;
        n = 0;
        while (rsp.ready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 0 || rsp.ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_latency addr=%h: extra_cycles=%0d ready=%b, required 0 and 1", a, n, rsp.ready);
        end
        rd = rsp.rdata; er = rsp.error; ack_en = enable; ack_done = cfg_done;
        @(negedge clk);
        checks++;
        if (rsp.ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_pulse addr=%h: ready=%b, required 0", a, rsp.ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = '0;
        viol = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({enable, cfg_done, irq, rsp.ready, rsp.error} !== 5'b0 || rsp.rdata !== 32'd0 || budget !== '0) begin
            failures++;
            $display("FAIL reset_outputs: en=%b done=%b irq=%b rdy=%b err=%b rdata=%h, required all 0",
                     enable, cfg_done, irq, rsp.ready, rsp.error, rsp.rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ctrl;
        access(32'h00, 1'b1, 32'h1, 4'h1, '0);
        checks++;
        if (er !== 1'b0 || ack_en !== 1'b1) begin
            failures++;
            $display("FAIL ctrl_write: error=%b enable=%b, required 0 and 1", er, ack_en);
        end
        access(32'h00, 1'b0, 32'h0, 4'h0, '0);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL ctrl_read: rdata=%h, required 00000001", rd);
        end
    endtask

    task automatic test_budgets;
        logic [31:0] vals [10];
        vals = '{32'h10, 32'hF0, 32'hA0, 32'h10, 32'h10, 32'h100, 32'h1, 32'h1, 32'h1, 32'h1};
        for (int i = 0; i < 10; i++) begin
            access(32'(4 * (i + 1)), 1'b1, vals[i], 4'hF, '0);
            checks++;
            if (ack_done !== (i == 9)) begin
                failures++;
                $display("FAIL cfg_done idx=%0d: got %b, required %b", i, ack_done, (i == 9));
            end
        end
        for (int i = 0; i < 10; i++) begin
            access(32'(4 * (i + 1)), 1'b0, 32'h0, 4'h0, '0);
            checks++;
            if (rd !== vals[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL budget_read idx=%0d: rdata=%h err=%b, required %h and 0", i, rd, er, vals[i]);
            end
        end
        checks++;
        if (budget[5] !== 32'h100) begin
            failures++;
            $display("FAIL budget_out5: got %h, required 00000100", budget[5]);
        end
    endtask

    task automatic test_strobe;
        access(32'h08, 1'b1, 32'hDEADBEEF, 4'h3, '0);
        access(32'h08, 1'b0, 32'h0, 4'h0, '0);
        checks++;
        if (rd !== 32'h0000BEEF) begin
            failures++;
            $display("FAIL strobe_read: rdata=%h, required 0000BEEF", rd);
        end
        access(32'h00, 1'b1, 32'h0, 4'h0, '0);
        checks++;
        if (er !== 1'b0 || ack_en !== 1'b1) begin
            failures++;
            $display("FAIL zero_strobe: error=%b enable=%b, required 0 and 1", er, ack_en);
        end
    endtask

    task automatic test_errors;
        access(32'h34, 1'b1, 32'hFFFF_FFFF, 4'hF, '0);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_0x34: error=%b rdata=%h, required 1 and 0", er, rd);
        end
        access(32'h06, 1'b1, 32'hFFFF_FFFF, 4'hF, '0);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL err_0x06: error=%b rdata=%h, required 1 and 0", er, rd);
        end
        access(32'h04, 1'b0, 32'h0, 4'h0, '0);
        checks++;
        if (rd !== 32'h10) begin
            failures++;
            $display("FAIL err_no_effect: budget0=%h, required 00000010", rd);
        end
    endtask

    task automatic test_irq;
        access(32'h30, 1'b1, 32'h004, 4'hF, '0);
        @(negedge clk); viol = 10'h004;
        @(negedge clk); viol = '0;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rise: irq=%b, required 1", irq);
        end
        @(negedge clk); viol = 10'h008;
        @(negedge clk); viol = '0;
        access(32'h2C, 1'b0, 32'h0, 4'h0, '0);
        checks++;
        if (rd !== 32'h00C || irq !== 1'b1) begin
            failures++;
            $display("FAIL status_set: status=%h irq=%b, required 0000000c and 1", rd, irq);
        end
        access(32'h2C, 1'b1, 32'h004, 4'hF, 10'h004);
        access(32'h2C, 1'b0, 32'h0, 4'h0, '0);
        checks++;
        if (rd !== 32'h00C || irq !== 1'b1) begin
            failures++;
            $display("FAIL set_wins: status=%h irq=%b, required 0000000c and 1", rd, irq);
        end
        access(32'h2C, 1'b1, 32'h004, 4'hF, '0);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear: irq=%b, required 0", irq);
        end
        access(32'h2C, 1'b0, 32'h0, 4'h0, '0);
        checks++;
        if (rd !== 32'h008) begin
            failures++;
            $display("FAIL w1c_clear: status=%h, required 00000008", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] seen;
        @(negedge clk);
        req.addr = 32'h00; req.write = 1'b0; req.wdata = '0; req.wstrb = '0; req.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen[i] = rsp.ready;
            if (i == 2) req.valid = 1'b0;
        end
        checks++;
        if (seen !== 4'b0101) begin
            failures++;
            $display("FAIL back_to_back: ready pattern=%b, required 0101", seen);
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        req.addr = 32'h04; req.write = 1'b1; req.wdata = 32'h55; req.wstrb = 4'hF; req.valid = 1'b1;
        @(negedge clk);
        req.valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp.ready !== 1'b0) begin
            failures++;
            $display("FAIL async_ready_drop: ready=%b, required 0", rsp.ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (budget[0] !== 32'd0 || cfg_done !== 1'b0 || enable !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: budget0=%h done=%b en=%b, required 0 0 0", budget[0], cfg_done, enable);
        end
        access(32'h04, 1'b0, 32'h0, 4'h0, '0);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_read: budget0=%h, required 00000000", rd);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ctrl();
        test_budgets();
        test_strobe();
        test_errors();
        test_irq();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/slv_guard_cfg_regs.md
Name: slv_guard_cfg_regs

Overview:
Register-bus responder (target) for the slave guard's configuration space. Accepts reg_req_t writes and reads from a reg-bus initiator and returns reg_rsp_t with a registered one-cycle-latency handshake. Holds the enable bit and the ten phase budgets, and exposes them to the guard's monitoring counters. Collects budget-violation events into a W1C status register and drives a maskable interrupt.

Parameters:
AddrWidth, 32, reg-bus address width
CntWidth, 32, width of each budget output (LSBs of the 32-bit register; CntWidth <= 32)
BaseAddr, 32'h0, base address of the register window
reg_req_t, logic, reg-bus request struct (addr, write, wdata[31:0], wstrb[3:0], valid)
reg_rsp_t, logic, reg-bus response struct (rdata[31:0], error, ready)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
reg_req_i  in  reg_req_t  configuration request
reg_rsp_o  out  reg_rsp_t  configuration response
enable_o  out  1  guard enable (reg 0x00 bit 0)
budget_o  out  10xCntWidth  budgets; index 0..9 map to offsets 0x04..0x28
cfg_done_o  out  1  every budget written at least once since reset
viol_i  in  10  one-cycle violation pulses, one per budget index
irq_o  out  1  registered OR of (status & mask)

Behaviour:
- Clocking and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: all registers 0; written flags 0; FSM in IDLE. Outputs during reset: enable_o=0, budget_o=0, cfg_done_o=0, irq_o=0, reg_rsp_o.ready=0, reg_rsp_o.error=0, reg_rsp_o.rdata=0.
- Register map, as offsets from BaseAddr:
  - 0x00 CTRL (bit0 enable; other bits read 0)
  - 0x04..0x28 BUDGET[0..9], 32-bit RW
  - 0x2C STATUS[9:0], W1C
  - 0x30 MASK[9:0], RW
- FSM states: IDLE and ACK.
  - IDLE: reg_req_i.valid=1 moves to ACK. On that edge, capture the write side effect, rdata and error.
  - ACK: ready=1 for exactly one cycle, with rdata/error valid. Always return to IDLE.
  - ready=0 in IDLE. Throughput is one access per 2 cycles.
  - A valid still high in the cycle after ACK starts a new access.
- Decode:
  - offset = addr - BaseAddr.
  - Error (error=1, rdata=0, no state change) if offset[1:0]!=0, offset>0x30, or addr<BaseAddr.
- Writes:
  - Per byte lane, gated by wstrb.
  - Any write to BUDGET[i] with wstrb!=0 sets written[i].
  - wstrb=0 gives ready with error=0 and no effect.
  - Reads return the current register value. Unused bits read 0.
- cfg_done_o = &written. It is sticky until reset.
- budget_o[i] = BUDGET[i][CntWidth-1:0]. It updates the cycle after the write edge (the ACK cycle).
- STATUS:
  - viol_i[i]=1 sets bit i.
  - Writing 1 to bit i clears it.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- irq_o is a register: irq_o <= |(STATUS_next & MASK). This gives 1-cycle latency from the viol_i pulse to irq_o.
- Reset mid-access: the FSM returns to IDLE immediately. The pending write is discarded and ready drops asynchronously.
- The enable bit does not lock the budgets. Budgets are writable at any time.

Test Plan:
- Reset, then write 0x00=0x1 with wstrb 0x1 -> ready one cycle after the valid edge, error=0; enable_o=1 in the ACK cycle; read 0x00 returns 0x00000001.
- Write BUDGET offsets 0x04..0x28 with 0x10, 0xF0, 0xA0, 0x10, 0x10, 0x100, 0x1, 0x1, 0x1, 0x1:
  - cfg_done_o stays 0 until the 10th write and is 1 in its ACK cycle.
  - Read-back of every budget matches.
  - budget_o[5]=0x100.
- Write 0x08=0xDEADBEEF with wstrb 0x3 after 0xF0 is stored -> read returns 0x0000BEEF.
- Access 0x34 and 0x06:
  - Each gives error=1, rdata=0, ready asserted.
  - No register changes.
- Violation and interrupt:
  - Write MASK=0x004, then pulse viol_i[2] -> STATUS=0x004 and irq_o=1 on the next cycle.
  - Pulse viol_i[3] -> irq_o stays tied to bit 2 only.
  - Write 0x2C=0x004 in the same cycle as a viol_i[2] pulse -> bit 2 remains set.
  - Clear again with no pulse -> irq_o=0.
- Assert rst_ni low during the ACK cycle of a write to 0x04 -> ready=0 immediately, BUDGET[0]=0 and written[0]=0 after reset.
